// File: rtl/stoch_decode_mat.sv
// Stochastic bitstream matrix decoder: counts ones per element over a 2**WIN_BITS window.
// Define STOCH_DECODE_BIPOLAR_EN to emit 2*count - N in two's complement instead.
module stoch_decode_mat #(
  parameter int NUM_ROWS = 3,
  parameter int NUM_COLS = 3,
  parameter int WIN_BITS = 8
) (
  input  logic CLK,
  input  logic nRST,
  input  logic en,
  input  logic clr,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0] A,
  output logic out_valid,
  input  logic out_ready,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0][WIN_BITS+1:0] Y,
  output logic overrun
);

  localparam int YW = WIN_BITS + 2;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t state;
  state_t state_nx;

  logic [WIN_BITS-1:0] cnt;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][WIN_BITS-1:0] acc;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][YW-1:0] res;
  logic done;
  logic load;
  logic drop;

  // cnt all ones marks sample N-1; clr suppresses completion
  assign done = en & ~clr & (cnt == '1);

  assign out_valid = (state == HOLD);

  always_comb begin
    res = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      for (int j = 0; j < NUM_COLS; j++) begin
        logic [WIN_BITS:0] c;
        c = {1'b0, acc[i][j]} + {{WIN_BITS{1'b0}}, A[i][j]};
`ifdef STOCH_DECODE_BIPOLAR_EN
        res[i][j] = {c, 1'b0} - (YW'(1) << WIN_BITS);
`else
        res[i][j] = {1'b0, c};
`endif
      end
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    drop     = 1'b0;
    unique case (state)
      ACCUM: begin
        if (done) begin
          load     = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (done) begin
          load = out_ready;
          drop = ~out_ready;
        end else if (out_ready) begin
          state_nx = ACCUM;
        end
      end
      default: state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= ACCUM;
      cnt     <= '0;
      acc     <= '0;
      Y       <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) Y <= res;
      if (drop) overrun <= 1'b1;
      if (clr) begin
        cnt <= '0;
        acc <= '0;
      end else if (en) begin
        cnt <= cnt + 1'b1;
        for (int i = 0; i < NUM_ROWS; i++) begin
          for (int j = 0; j < NUM_COLS; j++) begin
            acc[i][j] <= done ? '0
                       : acc[i][j] + WIN_BITS'(A[i][j]);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_stoch_decode_mat.sv
// Bench for stoch_decode_mat at WIN_BITS=4, 2x2: table vectors plus
// hand sequences for handshake, overrun, clr and reset corners.
module tb_stoch_decode_mat;

  typedef logic [1:0][1:0][5:0] ymat_t;

  typedef struct {
    logic [15:0] s00, s01, s10, s11;
    int c00, c01, c10, c11;
  } vec_t;

  logic CLK = 1'b0;
  logic nRST;
  logic en;
  logic clr;
  logic [1:0][1:0] A;
  logic out_valid;
  logic out_ready;
  ymat_t Y;
  logic overrun;

  int nvec = 0;
  int nbad = 0;
  ymat_t q[$];
  vec_t tbl[5];

  stoch_decode_mat #(
    .NUM_ROWS(2),
    .NUM_COLS(2),
    .WIN_BITS(4)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .en(en),
    .clr(clr),
    .A(A),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Y(Y),
    .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  function automatic logic [5:0] yv(int c);
`ifdef STOCH_DECODE_BIPOLAR_EN
    return 6'(2 * c - 16);
`else
    return 6'(c);
`endif
  endfunction

  function automatic ymat_t yexp(int c00, int c01, int c10, int c11);
    ymat_t y;
    y[0][0] = yv(c00);
    y[0][1] = yv(c01);
    y[1][0] = yv(c10);
    y[1][1] = yv(c11);
    return y;
  endfunction

  function automatic logic [1:0][1:0] samp(vec_t v, int k);
    logic [1:0][1:0] a;
    a[0][0] = v.s00[k];
    a[0][1] = v.s01[k];
    a[1][0] = v.s10[k];
    a[1][1] = v.s11[k];
    return a;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic e, input logic c, input logic [1:0][1:0] a);
    en  = e;
    clr = c;
    A   = a;
    @(posedge CLK);
    #1;
    en  = 1'b0;
    clr = 1'b0;
    A   = '0;
  endtask

  task automatic drain(string nm);
    repeat (2) cyc(1'b0, 1'b0, 4'h0);
    chk(nm, 64'(q.size()), 64'd0);
  endtask

  // scoreboard: every handshake must match the oldest expected result
  always @(negedge CLK) begin
    if (nRST === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        nvec++;
        nbad++;
        $display("FAIL unexpected_result: got %0h expected none at %0t", Y, $time);
      end else begin
        chk("result", 64'(Y), 64'(q.pop_front()));
      end
    end
  end

  initial begin
    tbl[0] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16, 16, 16, 16};
    tbl[1] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0};
    tbl[2] = '{16'hAAAA, 16'h1111, 16'h0000, 16'h0000, 8, 4, 0, 0};
    tbl[3] = '{16'hFFFE, 16'h0001, 16'h00FF, 16'h0F0F, 15, 1, 8, 8};
    tbl[4] = '{16'h8000, 16'h7FFF, 16'h5555, 16'hF000, 1, 15, 8, 4};

    nRST = 1'b0;
    en = 1'b0;
    clr = 1'b0;
    A = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_y", 64'(Y), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    nRST = 1'b1;

    for (int v = 0; v < 5; v++) begin
      q.push_back(yexp(tbl[v].c00, tbl[v].c01, tbl[v].c10, tbl[v].c11));
      for (int k = 0; k < 16; k++) begin
        cyc(1'b1, 1'b0, samp(tbl[v], k));
        if (k == 14) chk("pre_valid", 64'(out_valid), 64'd0);
      end
      chk("valid_lat", 64'(out_valid), 64'd1);
    end
    drain("table_drain");

    // en toggling: 16 accepted samples across 32 cycles, junk on A when idle
    q.push_back(yexp(8, 4, 0, 0));
    for (int k = 0; k < 32; k++) begin
      if (k % 2 == 0) cyc(1'b1, 1'b0, samp(tbl[2], k / 2));
      else cyc(1'b0, 1'b0, 4'($urandom));
    end
    drain("toggle_drain");

    // completion coincides with handshake
    out_ready = 1'b0;
    q.push_back(yexp(16, 16, 16, 16));
    q.push_back(yexp(15, 1, 8, 8));
    for (int k = 0; k < 16; k++) cyc(1'b1, 1'b0, 4'hF);
    chk("hold_valid", 64'(out_valid), 64'd1);
    for (int k = 0; k < 15; k++) cyc(1'b1, 1'b0, samp(tbl[3], k));
    out_ready = 1'b1;
    cyc(1'b1, 1'b0, samp(tbl[3], 15));
    chk("coinc_valid", 64'(out_valid), 64'd1);
    chk("coinc_overrun", 64'(overrun), 64'd0);
    drain("coinc_drain");
    chk("coinc_idle", 64'(out_valid), 64'd0);

    // overrun: consumer stalled across two completions
    out_ready = 1'b0;
    q.push_back(yexp(16, 16, 16, 16));
    for (int k = 0; k < 40; k++) begin
      cyc(1'b1, 1'b0, 4'hF);
      if (k == 15) chk("ovr_valid", 64'(out_valid), 64'd1);
      if (k == 30) chk("ovr_pre", 64'(overrun), 64'd0);
      if (k == 31) chk("ovr_set", 64'(overrun), 64'd1);
    end
    chk("ovr_y_kept", 64'(Y), 64'(yexp(16, 16, 16, 16)));
    out_ready = 1'b1;
    cyc(1'b0, 1'b0, 4'h0);
    chk("ovr_drop_valid", 64'(out_valid), 64'd0);
    chk("ovr_sticky", 64'(overrun), 64'd1);
    chk("ovr_drain", 64'(q.size()), 64'd0);

    // clr at sample 10
    cyc(1'b0, 1'b1, 4'h0);
    q.push_back(yexp(8, 4, 0, 0));
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b0, 4'hF);
    cyc(1'b1, 1'b1, 4'hF);
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, 1'b0, samp(tbl[2], k));
      if (k == 14) chk("clr10_pre", 64'(out_valid), 64'd0);
    end
    chk("clr10_valid", 64'(out_valid), 64'd1);
    drain("clr10_drain");

    // clr on the completing sample
    q.push_back(yexp(16, 16, 16, 16));
    for (int k = 0; k < 15; k++) cyc(1'b1, 1'b0, 4'h0);
    cyc(1'b1, 1'b1, 4'hF);
    chk("clr15_none", 64'(out_valid), 64'd0);
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, 1'b0, 4'hF);
      if (k == 14) chk("clr15_pre", 64'(out_valid), 64'd0);
    end
    chk("clr15_valid", 64'(out_valid), 64'd1);
    drain("clr15_drain");

    // reset mid-window
    for (int k = 0; k < 7; k++) cyc(1'b1, 1'b0, 4'hF);
    nRST = 1'b0;
    cyc(1'b1, 1'b0, 4'hF);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_y", 64'(Y), 64'd0);
    chk("mid_rst_overrun", 64'(overrun), 64'd0);
    nRST = 1'b1;
    q.push_back(yexp(16, 16, 16, 16));
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, 1'b0, 4'hF);
      if (k == 14) chk("post_rst_pre", 64'(out_valid), 64'd0);
    end
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    drain("post_rst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
